// File: rtl/int_wb_arbiter_pkg.sv
// rtl/int_wb_arbiter_pkg.sv - shared core types for the integer writeback arbiter
package int_wb_arbiter_pkg;
  localparam int XDEF       = 64;
  localparam int ROB_IDX_W  = 7;
  localparam int IROB_IDX_W = 5;
  localparam int IPR_IDX_W  = 7;

  typedef logic [IPR_IDX_W-1:0]  iprIdx_t;
  typedef logic [ROB_IDX_W-1:0]  robIdx_t;
  typedef logic [IROB_IDX_W-1:0] irobIdx_t;

  typedef struct packed {
    robIdx_t         rob_idx;
    irobIdx_t        irob_idx;
    logic            use_imm;
    logic            rd_wen;
    iprIdx_t         iprd_idx;
    logic [XDEF-1:0] result;
  } comwbInfo_t;
endpackage

// File: rtl/int_wb_arbiter_if.sv
// rtl/int_wb_arbiter_if.sv - FU result requests in, writeback/completion ports out
interface int_wb_arbiter_if
  import int_wb_arbiter_pkg::*;
#(
  parameter int FU_NUM      = 4,
  parameter int WB_PORT_NUM = 2
) ();
  logic       [FU_NUM-1:0]                 i_fu_finished;
  comwbInfo_t [FU_NUM-1:0]                 i_comwbInfo;
  logic       [FU_NUM-1:0]                 o_wb_stall;
  logic       [WB_PORT_NUM-1:0]            o_wb_vld;
  robIdx_t    [WB_PORT_NUM-1:0]            o_wb_rob_idx;
  irobIdx_t   [WB_PORT_NUM-1:0]            o_wb_irob_idx;
  logic       [WB_PORT_NUM-1:0]            o_wb_use_imm;
  logic       [WB_PORT_NUM-1:0]            o_rf_wen;
  iprIdx_t    [WB_PORT_NUM-1:0]            o_rf_idx;
  logic       [WB_PORT_NUM-1:0][XDEF-1:0]  o_rf_data;

  modport slave (
    input  i_fu_finished, i_comwbInfo,
    output o_wb_stall, o_wb_vld, o_wb_rob_idx, o_wb_irob_idx, o_wb_use_imm,
           o_rf_wen, o_rf_idx, o_rf_data
  );

  modport master (
    output i_fu_finished, i_comwbInfo,
    input  o_wb_stall, o_wb_vld, o_wb_rob_idx, o_wb_irob_idx, o_wb_use_imm,
           o_rf_wen, o_rf_idx, o_rf_data
  );
endinterface

// File: rtl/int_wb_arbiter_rr_multi_select.sv
// rtl/int_wb_arbiter_rr_multi_select.sv - combinational round-robin pick of up to M of N requests
module int_wb_arbiter_rr_multi_select #(
  parameter int N  = 4,
  parameter int M  = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]          i_req,
  input  logic [PW-1:0]         i_start,
  output logic [M-1:0][N-1:0]   o_gnt,
  output logic [M-1:0]          o_vld,
  output logic [PW-1:0]         o_last
);
  always_comb begin
    int cnt;
    int idx;
    o_gnt  = '0;
    o_vld  = '0;
    o_last = '0;
    cnt    = 0;
    // The k-th hit in circular scan order lands on port k.
    for (int off = 0; off < N; off++) begin
      idx = int'(i_start) + off;
      if (idx >= N) idx = idx - N;
      if (i_req[idx] && (cnt < M)) begin
        o_gnt[cnt][idx] = 1'b1;
        o_vld[cnt]      = 1'b1;
        o_last          = PW'(idx);
        cnt             = cnt + 1;
      end
    end
  end
endmodule

// File: rtl/int_wb_arbiter.sv
// rtl/int_wb_arbiter.sv - grants up to WB_PORT_NUM finished FUs per cycle, stalls the rest
module int_wb_arbiter
  import int_wb_arbiter_pkg::*;
#(
  parameter int FU_NUM      = 4,
  parameter int WB_PORT_NUM = 2
) (
  input  logic            clk,
  input  logic            rst,
  int_wb_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(FU_NUM);

  logic       [PTR_W-1:0]                  rr_ptr_q, rr_ptr_d;
  logic       [WB_PORT_NUM-1:0][FU_NUM-1:0] gnt;
  logic       [WB_PORT_NUM-1:0]            port_vld;
  logic       [PTR_W-1:0]                  last_idx;
  logic       [FU_NUM-1:0]                 gnt_any;
  logic       [WB_PORT_NUM-1:0]            wb_vld_q, wb_vld_d;
  comwbInfo_t [WB_PORT_NUM-1:0]            info_q, info_d;

  int_wb_arbiter_rr_multi_select #(
    .N (FU_NUM),
    .M (WB_PORT_NUM)
  ) u_select (
    .i_req   (bus.i_fu_finished),
    .i_start (rr_ptr_q),
    .o_gnt   (gnt),
    .o_vld   (port_vld),
    .o_last  (last_idx)
  );

  always_comb begin
    gnt_any  = '0;
    info_d   = '0;
    wb_vld_d = port_vld;
    // AND-OR mux: ungranted FUs contribute zeros, so their X fields never leak.
    for (int k = 0; k < WB_PORT_NUM; k++) begin
      gnt_any = gnt_any | gnt[k];
      for (int i = 0; i < FU_NUM; i++) begin
        info_d[k] = info_d[k] | ({$bits(comwbInfo_t){gnt[k][i]}} & bus.i_comwbInfo[i]);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (port_vld[0]) begin
      rr_ptr_d = (last_idx == PTR_W'(FU_NUM - 1)) ? '0 : last_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_q <= '0;
      wb_vld_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wb_vld_q <= wb_vld_d;
    end
    info_q <= info_d;
  end

  assign bus.o_wb_stall = rst ? (bus.i_fu_finished & ~gnt_any) : '0;
  assign bus.o_wb_vld   = wb_vld_q;

  always_comb begin
    for (int k = 0; k < WB_PORT_NUM; k++) begin
      bus.o_wb_rob_idx[k]  = info_q[k].rob_idx;
      bus.o_wb_irob_idx[k] = info_q[k].irob_idx;
      bus.o_wb_use_imm[k]  = info_q[k].use_imm;
      bus.o_rf_wen[k]      = wb_vld_q[k] & info_q[k].rd_wen;
      bus.o_rf_idx[k]      = info_q[k].iprd_idx;
      bus.o_rf_data[k]     = info_q[k].result;
    end
  end
endmodule

// File: tb/tb_int_wb_arbiter.sv
// tb/tb_int_wb_arbiter.sv - self-checking bench for int_wb_arbiter
module tb_int_wb_arbiter;
  import int_wb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int_wb_arbiter_if #(.FU_NUM(4), .WB_PORT_NUM(2)) bus_a ();
  int_wb_arbiter_if #(.FU_NUM(4), .WB_PORT_NUM(1)) bus_b ();

  int_wb_arbiter #(.FU_NUM(4), .WB_PORT_NUM(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  int_wb_arbiter #(.FU_NUM(4), .WB_PORT_NUM(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  int total = 0;
  int bad   = 0;
  int m_ptr = 0;
  int m_g[4];
  int m_n;
  comwbInfo_t fu_info[4];
  logic [3:0] fu_pend;

  function automatic comwbInfo_t mk_info(input int rob, input int irob, input logic imm,
                                         input logic wen, input int iprd, input logic [63:0] data);
    comwbInfo_t r;
    r.rob_idx  = robIdx_t'(rob);
    r.irob_idx = irobIdx_t'(irob);
    r.use_imm  = imm;
    r.rd_wen   = wen;
    r.iprd_idx = iprIdx_t'(iprd);
    r.result   = data;
    return r;
  endfunction

  // Reference: walk FU indices circularly from ptr, first `ports` requesters win.
  task automatic model_sel(input logic [3:0] req, input int ptr, input int ports);
    m_n = 0;
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (ptr + k) % 4;
      if (req[idx] && m_n < ports) begin
        m_g[m_n] = idx;
        m_n++;
      end
    end
  endtask

  task automatic drive_a(input logic [3:0] req);
    bus_a.i_fu_finished = req;
    for (int i = 0; i < 4; i++) bus_a.i_comwbInfo[i] = req[i] ? fu_info[i] : 'x;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) fu_info[i] = mk_info(i, i, 1'b0, 1'b1, i, 64'(i));
    drive_a(4'b1111);
    bus_b.i_fu_finished = 4'b1111;
    for (int i = 0; i < 4; i++) bus_b.i_comwbInfo[i] = fu_info[i];
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      total++; if (bus_a.o_wb_stall !== 4'b0000) begin bad++; $display("FAIL reset_stall_a: got %b want 0000", bus_a.o_wb_stall); end
      total++; if (bus_b.o_wb_stall !== 4'b0000) begin bad++; $display("FAIL reset_stall_b: got %b want 0000", bus_b.o_wb_stall); end
      @(posedge clk); #1;
      total++; if (bus_a.o_wb_vld !== 2'b00) begin bad++; $display("FAIL reset_vld: got %b want 00", bus_a.o_wb_vld); end
      total++; if (bus_a.o_rf_wen !== 2'b00) begin bad++; $display("FAIL reset_wen: got %b want 00", bus_a.o_rf_wen); end
    end
    @(negedge clk);
    rst = 1'b1;
    drive_a(4'b0000);
    bus_b.i_fu_finished = 4'b0000;
    @(posedge clk); #1;
    total++; if (dut_a.rr_ptr_q !== 2'd0) begin bad++; $display("FAIL reset_ptr: got %0d want 0", dut_a.rr_ptr_q); end
    total++; if (bus_a.o_wb_vld !== 2'b00) begin bad++; $display("FAIL reset_release_vld: got %b want 00", bus_a.o_wb_vld); end
    m_ptr = 0;
  endtask

  task automatic test_single;
    fu_info[2] = mk_info(5, 2, 1'b0, 1'b1, 17, 64'hDEAD);
    @(negedge clk);
    drive_a(4'b0100);
    #1;
    total++; if (bus_a.o_wb_stall !== 4'b0000) begin bad++; $display("FAIL single_stall: got %b want 0000", bus_a.o_wb_stall); end
    @(posedge clk); #1;
    total++; if (bus_a.o_wb_vld !== 2'b01) begin bad++; $display("FAIL single_vld: got %b want 01", bus_a.o_wb_vld); end
    total++; if (bus_a.o_rf_wen !== 2'b01) begin bad++; $display("FAIL single_wen: got %b want 01", bus_a.o_rf_wen); end
    total++; if (bus_a.o_rf_idx[0] !== 7'd17) begin bad++; $display("FAIL single_idx: got %0d want 17", bus_a.o_rf_idx[0]); end
    total++; if (bus_a.o_rf_data[0] !== 64'hDEAD) begin bad++; $display("FAIL single_data: got %h want dead", bus_a.o_rf_data[0]); end
    total++; if (bus_a.o_wb_rob_idx[0] !== 7'd5) begin bad++; $display("FAIL single_rob: got %0d want 5", bus_a.o_wb_rob_idx[0]); end
    total++; if (dut_a.rr_ptr_q !== 2'd3) begin bad++; $display("FAIL single_ptr: got %0d want 3", dut_a.rr_ptr_q); end
    @(negedge clk);
    drive_a(4'b0000);
    @(posedge clk); #1;
    total++; if (bus_a.o_wb_vld !== 2'b00) begin bad++; $display("FAIL single_one_cycle: got %b want 00", bus_a.o_wb_vld); end
    m_ptr = 3;
  endtask

  task automatic test_wrap;
    fu_info[3] = mk_info(33, 3, 1'b1, 1'b1, 3, 64'h3333);
    fu_info[0] = mk_info(30, 0, 1'b0, 1'b1, 9, 64'h3030);
    @(negedge clk);
    drive_a(4'b1001);
    #1;
    total++; if (bus_a.o_wb_stall !== 4'b0000) begin bad++; $display("FAIL wrap_stall: got %b want 0000", bus_a.o_wb_stall); end
    @(posedge clk); #1;
    total++; if (bus_a.o_wb_vld !== 2'b11) begin bad++; $display("FAIL wrap_vld: got %b want 11", bus_a.o_wb_vld); end
    total++; if (bus_a.o_wb_rob_idx[0] !== 7'd33) begin bad++; $display("FAIL wrap_port0: got %0d want 33", bus_a.o_wb_rob_idx[0]); end
    total++; if (bus_a.o_wb_rob_idx[1] !== 7'd30) begin bad++; $display("FAIL wrap_port1: got %0d want 30", bus_a.o_wb_rob_idx[1]); end
    total++; if (bus_a.o_wb_use_imm !== 2'b01) begin bad++; $display("FAIL wrap_imm: got %b want 01", bus_a.o_wb_use_imm); end
    total++; if (dut_a.rr_ptr_q !== 2'd1) begin bad++; $display("FAIL wrap_ptr: got %0d want 1", dut_a.rr_ptr_q); end
    m_ptr = 1;
  endtask

  task automatic test_oversub;
    int wr_cnt[4];
    for (int i = 0; i < 4; i++) wr_cnt[i] = 0;
    fu_info[3] = mk_info(99, 0, 1'b0, 1'b0, 0, 64'h0);
    @(negedge clk);
    drive_a(4'b1000);
    @(posedge clk); #1;
    total++; if (dut_a.rr_ptr_q !== 2'd0) begin bad++; $display("FAIL over_pre_ptr: got %0d want 0", dut_a.rr_ptr_q); end
    for (int i = 0; i < 4; i++) fu_info[i] = mk_info(40 + i, i, 1'b0, 1'b1, 20 + i, 64'(100 + i));
    @(negedge clk);
    drive_a(4'b1111);
    #1;
    total++; if (bus_a.o_wb_stall !== 4'b1100) begin bad++; $display("FAIL over_stall_t: got %b want 1100", bus_a.o_wb_stall); end
    @(posedge clk); #1;
    total++; if (bus_a.o_wb_rob_idx[0] !== 7'd40 || bus_a.o_wb_rob_idx[1] !== 7'd41) begin
      bad++; $display("FAIL over_grant_t: got %0d,%0d want 40,41", bus_a.o_wb_rob_idx[0], bus_a.o_wb_rob_idx[1]); end
    for (int k = 0; k < 2; k++) if (bus_a.o_wb_vld[k]) wr_cnt[(int'(bus_a.o_wb_rob_idx[k]) - 40) & 3]++;
    @(negedge clk);
    drive_a(4'b1100);
    #1;
    total++; if (bus_a.o_wb_stall !== 4'b0000) begin bad++; $display("FAIL over_stall_t1: got %b want 0000", bus_a.o_wb_stall); end
    @(posedge clk); #1;
    total++; if (bus_a.o_wb_rob_idx[0] !== 7'd42 || bus_a.o_wb_rob_idx[1] !== 7'd43) begin
      bad++; $display("FAIL over_grant_t1: got %0d,%0d want 42,43", bus_a.o_wb_rob_idx[0], bus_a.o_wb_rob_idx[1]); end
    total++; if (dut_a.rr_ptr_q !== 2'd0) begin bad++; $display("FAIL over_ptr_wrap: got %0d want 0", dut_a.rr_ptr_q); end
    for (int k = 0; k < 2; k++) if (bus_a.o_wb_vld[k]) wr_cnt[(int'(bus_a.o_wb_rob_idx[k]) - 40) & 3]++;
    @(negedge clk);
    drive_a(4'b0000);
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) if (bus_a.o_wb_vld[k]) wr_cnt[(int'(bus_a.o_wb_rob_idx[k]) - 40) & 3]++;
    for (int i = 0; i < 4; i++) begin
      total++; if (wr_cnt[i] !== 1) begin bad++; $display("FAIL over_once_fu%0d: got %0d writes want 1", i, wr_cnt[i]); end
    end
    m_ptr = 0;
  endtask

  task automatic test_nowen;
    fu_info[1] = mk_info(50, 1, 1'b0, 1'b0, 11, 64'h5050);
    @(negedge clk);
    drive_a(4'b0010);
    @(posedge clk); #1;
    total++; if (bus_a.o_wb_vld !== 2'b01) begin bad++; $display("FAIL nowen_vld: got %b want 01", bus_a.o_wb_vld); end
    total++; if (bus_a.o_rf_wen !== 2'b00) begin bad++; $display("FAIL nowen_wen: got %b want 00", bus_a.o_rf_wen); end
    total++; if (bus_a.o_wb_rob_idx[0] !== 7'd50) begin bad++; $display("FAIL nowen_rob: got %0d want 50", bus_a.o_wb_rob_idx[0]); end
    m_ptr = 2;
  endtask

  task automatic test_starve;
    comwbInfo_t ib[2];
    int exp_fu;
    ib[0] = mk_info(60, 0, 1'b0, 1'b1, 1, 64'h60);
    ib[1] = mk_info(61, 1, 1'b0, 1'b1, 2, 64'h61);
    @(negedge clk);
    drive_a(4'b0000);
    for (int c = 0; c < 4; c++) begin
      if (c != 0) @(negedge clk);
      bus_b.i_fu_finished = 4'b0011;
      bus_b.i_comwbInfo[0] = ib[0];
      bus_b.i_comwbInfo[1] = ib[1];
      bus_b.i_comwbInfo[2] = 'x;
      bus_b.i_comwbInfo[3] = 'x;
      exp_fu = c % 2;
      #1;
      total++; if (bus_b.o_wb_stall !== ((exp_fu == 0) ? 4'b0010 : 4'b0001)) begin
        bad++; $display("FAIL starve_stall_c%0d: got %b want fu%0d granted", c, bus_b.o_wb_stall, exp_fu); end
      @(posedge clk); #1;
      total++; if (bus_b.o_wb_vld !== 1'b1 || bus_b.o_wb_rob_idx[0] !== ib[exp_fu].rob_idx) begin
        bad++; $display("FAIL starve_grant_c%0d: got vld=%b rob=%0d want vld=1 rob=%0d", c, bus_b.o_wb_vld, bus_b.o_wb_rob_idx[0], ib[exp_fu].rob_idx); end
      ib[exp_fu].rob_idx = ib[exp_fu].rob_idx + 7'd2;
    end
    @(negedge clk);
    bus_b.i_comwbInfo[0] = ib[0];
    bus_b.i_comwbInfo[1] = ib[1];
    #1;
    total++; if (bus_b.o_wb_stall !== 4'b0010) begin bad++; $display("FAIL starve_fu1_stalled: got %b want 0010", bus_b.o_wb_stall); end
    #1;
    rst = 1'b0;
    #1;
    total++; if (bus_b.o_wb_stall !== 4'b0000) begin bad++; $display("FAIL midrst_stall: got %b want 0000", bus_b.o_wb_stall); end
    @(posedge clk); #1;
    total++; if (bus_b.o_wb_vld !== 1'b0) begin bad++; $display("FAIL midrst_vld: got %b want 0", bus_b.o_wb_vld); end
    @(negedge clk);
    rst = 1'b1;
    bus_b.i_fu_finished = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      total++; if (bus_b.o_wb_vld !== 1'b0 || bus_b.o_rf_wen !== 1'b0) begin
        bad++; $display("FAIL midrst_no_wb_c%0d: got vld=%b wen=%b want 0,0", c, bus_b.o_wb_vld, bus_b.o_rf_wen); end
    end
    total++; if (dut_b.rr_ptr_q !== 2'd0) begin bad++; $display("FAIL midrst_ptr: got %0d want 0", dut_b.rr_ptr_q); end
    m_ptr = 0;
  endtask

  task automatic test_random;
    logic [3:0] exp_stall;
    logic [1:0] exp_vld, exp_wen;
    fu_pend = 4'b0000;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (!fu_pend[i] && $urandom_range(0, 99) < 60) begin
          fu_pend[i] = 1'b1;
          fu_info[i] = mk_info(int'($urandom_range(0, 127)), int'($urandom_range(0, 31)), 1'($urandom),
                               1'($urandom), int'($urandom_range(0, 127)), {$urandom, $urandom});
        end
      end
      drive_a(fu_pend);
      model_sel(fu_pend, m_ptr, 2);
      exp_stall = fu_pend;
      for (int j = 0; j < m_n; j++) exp_stall[m_g[j]] = 1'b0;
      #1;
      total++; if (bus_a.o_wb_stall !== exp_stall) begin bad++; $display("FAIL rnd_stall_c%0d: got %b want %b", cyc, bus_a.o_wb_stall, exp_stall); end
      @(posedge clk); #1;
      exp_vld = '0;
      exp_wen = '0;
      for (int k = 0; k < m_n; k++) begin
        exp_vld[k] = 1'b1;
        exp_wen[k] = fu_info[m_g[k]].rd_wen;
      end
      total++; if (bus_a.o_wb_vld !== exp_vld) begin bad++; $display("FAIL rnd_vld_c%0d: got %b want %b", cyc, bus_a.o_wb_vld, exp_vld); end
      total++; if (bus_a.o_rf_wen !== exp_wen) begin bad++; $display("FAIL rnd_wen_c%0d: got %b want %b", cyc, bus_a.o_rf_wen, exp_wen); end
      for (int k = 0; k < m_n; k++) begin
        total++;
        if (bus_a.o_wb_rob_idx[k] !== fu_info[m_g[k]].rob_idx || bus_a.o_wb_irob_idx[k] !== fu_info[m_g[k]].irob_idx ||
            bus_a.o_wb_use_imm[k] !== fu_info[m_g[k]].use_imm || bus_a.o_rf_idx[k] !== fu_info[m_g[k]].iprd_idx ||
            bus_a.o_rf_data[k] !== fu_info[m_g[k]].result) begin
          bad++;
          $display("FAIL rnd_fields_c%0d_p%0d: got rob=%0d idx=%0d data=%h want fu%0d rob=%0d idx=%0d data=%h", cyc, k,
                   bus_a.o_wb_rob_idx[k], bus_a.o_rf_idx[k], bus_a.o_rf_data[k], m_g[k],
                   fu_info[m_g[k]].rob_idx, fu_info[m_g[k]].iprd_idx, fu_info[m_g[k]].result);
        end
      end
      for (int k = 0; k < m_n; k++) fu_pend[m_g[k]] = 1'b0;
      if (m_n > 0) m_ptr = (m_g[m_n - 1] + 1) % 4;
      total++; if (int'(dut_a.rr_ptr_q) !== m_ptr) begin bad++; $display("FAIL rnd_ptr_c%0d: got %0d want %0d", cyc, dut_a.rr_ptr_q, m_ptr); end
    end
  endtask

  initial begin
    bus_a.i_fu_finished = '0;
    bus_a.i_comwbInfo   = '0;
    bus_b.i_fu_finished = '0;
    bus_b.i_comwbInfo   = '0;
    test_reset();
    test_single();
    test_wrap();
    test_oversub();
    test_nowen();
    test_starve();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/int_wb_arbiter.md
# int_wb_arbiter

Writeback arbiter for the integer backend: collects finished results from `FU_NUM` functional units, which present `fu_finished` plus a held `comwbInfo_t`. It grants up to `WB_PORT_NUM` of them per cycle onto the register-file write ports and ROB completion ports. It drives each FU's `i_wb_stall` so that ungranted FUs hold their result until granted. Rotating priority guarantees no FU starves.

## Interface
Parameters:
- `FU_NUM`, 4: number of FU writeback requesters; ≥2.
- `WB_PORT_NUM`, 2: writeback ports; 1 ≤ `WB_PORT_NUM` ≤ `FU_NUM`.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous reset, active-low (`rst==0` resets at posedge).
- `i_fu_finished`  in  `FU_NUM`  per-FU result valid; held high while that FU is stalled.
- `i_comwbInfo`  in  `comwbInfo_t[FU_NUM]`  per-FU result: `rob_idx`, `irob_idx`, `use_imm`, `rd_wen`, `iprd_idx`, `result`.
- `o_wb_stall`  out  `FU_NUM`  per-FU stall, returned to that FU's `i_wb_stall`.
- `o_wb_vld`  out  `WB_PORT_NUM`  ROB completion valid, registered.
- `o_wb_rob_idx`, `o_wb_irob_idx`, `o_wb_use_imm`  out  per port  completion info, registered.
- `o_rf_wen`  out  `WB_PORT_NUM`  regfile write enable, registered.
- `o_rf_idx`  out  `iprIdx_t[WB_PORT_NUM]`  physical rd, registered.
- `o_rf_data`  out  `[XDEF][WB_PORT_NUM]`  write data, registered.

## Operation
- Request vector is `req = i_fu_finished`.
- Round-robin pointer `rr_ptr` is `$clog2(FU_NUM)` bits, reset 0.
- Selection scans FU indices circularly starting at `rr_ptr` and grants the first `WB_PORT_NUM` set bits of `req`.
- The k-th grant, in scan order, goes to port k. Unused ports carry valid 0.
- Stall rule: `o_wb_stall[i] = req[i] & ~grant[i]`, combinational. A non-requesting FU is never stalled.
- Output stage, per port k, registered at posedge:
  - `o_wb_vld[k] <= port used`.
  - `o_rf_wen[k] <= port used & rd_wen`.
  - Info, idx and data fields are copied from the granted FU.
  - Fields of an unused port are don't-care. Only the valid and wen bits are cleared.
- Pointer update:
  - If any grant was made, `rr_ptr <= (index of last granted FU + 1) mod FU_NUM`. Wrap is explicit for non-power-of-2 `FU_NUM`.
  - If no grant was made, the pointer holds.
- Reset (`rst==0`):
  - `o_wb_vld`, `o_rf_wen` and `rr_ptr` go to 0 at the next posedge.
  - `o_wb_stall` is forced to 0 while reset is asserted. FUs are reset concurrently.
  - Reset mid-stall discards pending results; no writeback occurs for them.
- No internal storage of results. The FU is the buffer, so no full/overflow condition exists here.
- `X` on `i_comwbInfo` of a non-requesting FU must not propagate to any output.

## Timing
- Grant and stall: combinational in the same cycle as the request.
- Writeback latency: request granted in cycle t produces `o_wb_vld`/`o_rf_wen` high in cycle t+1 for exactly one cycle, per grant.
- FU handshake: a stalled FU keeps `i_fu_finished` and `i_comwbInfo` stable. The arbiter re-evaluates every cycle with the updated `rr_ptr`.
- Worst-case wait for any requester: `ceil(FU_NUM / WB_PORT_NUM)` - 1 stall cycles under continuous full load.
- Throughput: `WB_PORT_NUM` results per cycle.

## Structure
- `comwbInfo_t`, `iprIdx_t` and `XDEF` come from the shared core package/`core_define.svh`. No new typedefs are required.
- Sub-module `rr_multi_select`:
  - Parameters `N`, `M`.
  - Inputs: request mask and start pointer.
  - Outputs: `M` one-hot grant vectors plus per-port valid, and last-grant index.
  - Purely combinational; reused by other arbiters.
- Top level holds `rr_ptr`, the stall logic, and the registered output muxes.

## Test plan
- Reset: hold `rst=0` with `i_fu_finished=4'b1111`. Required: `o_wb_stall=0`, `o_wb_vld=0`, `o_rf_wen=0`. After release, `rr_ptr=0`.
- Single request: FU2 finishes with `rob_idx=5`, `rd_wen=1`, `iprd=17`, `result=0xDEAD`. Required: no stall; next cycle port0 has `vld=1`, `wen=1`, `idx=17`, `data=0xDEAD`; `rr_ptr=3`.
- Oversubscription: `req=4'b1111`, `rr_ptr=0`.
  - Cycle t: grants FU0→port0 and FU1→port1; `o_wb_stall=4'b1100`.
  - Cycle t+1: grants FU2 and FU3; `rr_ptr` wraps to 0.
  - All four results are written exactly once.
- Wrap scan: `rr_ptr=3`, `req=4'b1001`. Required: FU3→port0, FU0→port1, no stall; `rr_ptr=1`.
- `rd_wen=0` result: FU1 result with `rd_wen=0`. Required: `o_wb_vld=1`, `o_rf_wen=0`.
- Starvation/reset-mid-stall: FU0 and FU1 request continuously with `WB_PORT_NUM=1`.
  - Required: grants alternate 0,1,0,1.
  - Assert reset while FU1 is stalled: no writeback for FU1 after reset, and `o_wb_vld=0`.
